// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - operand request and result channels between sequencer, alu_pipe and writeback
interface alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALU_Sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALU_Out;
  logic             carry;
  logic             zero;
  logic             neg;
  logic             ovf;

  modport master (
    output in_valid, A, B, ALU_Sel, out_ready,
    input  in_ready, out_valid, ALU_Out, carry, zero, neg, ovf
  );

  modport slave (
    input  in_valid, A, B, ALU_Sel, out_ready,
    output in_ready, out_valid, ALU_Out, carry, zero, neg, ovf
  );
endinterface

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked ALU with registered result/flags and a one-slot output stage
// ALU_MUL_EN builds the IDLE/MUL shift-add multiplier; without it opcodes 2/3 return the illegal-op marker.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input logic       clk,
  input logic       rst_n,
  alu_pipe_if.slave bus
);
  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_MULH = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_ROL  = 4'd6;
  localparam logic [3:0] OP_ROR  = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_OR   = 4'd9;
  localparam logic [3:0] OP_XOR  = 4'd10;
  localparam logic [3:0] OP_NOR  = 4'd11;
  localparam logic [3:0] OP_NAND = 4'd12;
  localparam logic [3:0] OP_XNOR = 4'd13;
  localparam logic [3:0] OP_GT   = 4'd14;
  localparam logic [3:0] OP_EQ   = 4'd15;

  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  logic             slot_free;
  logic             accept;
  logic             load_single;
  logic             load_mul;
  logic [WIDTH-1:0] mul_res;
  logic             mul_carry;

  logic [WIDTH-1:0] op_res;
  logic             op_carry;
  logic             op_ovf;
  logic [WIDTH:0]   add_w, sub_w, shl_w, shr_w;
  logic [SW-1:0]    sh;

  assign slot_free = !out_valid_q || bus.out_ready;
  assign accept    = bus.in_valid && bus.in_ready;

  always_comb begin
    sh       = bus.B[SW-1:0];
    add_w    = {1'b0, bus.A} + {1'b0, bus.B};
    sub_w    = {1'b0, bus.A} - {1'b0, bus.B};
    shl_w    = {1'b0, bus.A} << sh;
    shr_w    = {bus.A, 1'b0} >> sh;
    op_res   = '0;
    op_carry = 1'b0;
    op_ovf   = 1'b0;
    case (bus.ALU_Sel)
      OP_ADD: begin
        op_res   = add_w[WIDTH-1:0];
        op_carry = add_w[WIDTH];
        op_ovf   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (add_w[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SUB: begin
        op_res   = sub_w[WIDTH-1:0];
        op_carry = sub_w[WIDTH];
        op_ovf   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (sub_w[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_MUL, OP_MULH: begin
`ifdef ALU_MUL_EN
        op_ovf = 1'b0;
`else
        // No multiplier built: ovf=1 with a zero result marks the op as illegal.
        op_ovf = 1'b1;
`endif
      end
      // The extra guard bit catches the last bit shifted out; it stays 0 for a zero shift.
      OP_SHL: begin
        op_res   = shl_w[WIDTH-1:0];
        op_carry = shl_w[WIDTH];
      end
      OP_SHR: begin
        op_res   = shr_w[WIDTH:1];
        op_carry = shr_w[0];
      end
      OP_ROL: begin
        op_res   = {bus.A[WIDTH-2:0], bus.A[WIDTH-1]};
        op_carry = bus.A[WIDTH-1];
      end
      OP_ROR: begin
        op_res   = {bus.A[0], bus.A[WIDTH-1:1]};
        op_carry = bus.A[0];
      end
      OP_AND:  op_res = bus.A & bus.B;
      OP_OR:   op_res = bus.A | bus.B;
      OP_XOR:  op_res = bus.A ^ bus.B;
      OP_NOR:  op_res = ~(bus.A | bus.B);
      OP_NAND: op_res = ~(bus.A & bus.B);
      OP_XNOR: op_res = ~(bus.A ^ bus.B);
      OP_GT:   op_res[0] = (bus.A > bus.B);
      OP_EQ:   op_res[0] = (bus.A == bus.B);
      default: op_res = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  typedef enum logic {S_IDLE, S_MUL} state_t;

  localparam logic [SW:0] CNT_INIT = (SW+1)'(WIDTH);
  localparam logic [SW:0] CNT_ONE  = (SW+1)'(1);

  state_t             state_q, state_d;
  logic [SW:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               mulh_q, mulh_d;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     step_sum;
  logic               is_mul_op;

  assign is_mul_op    = (bus.ALU_Sel == OP_MUL) || (bus.ALU_Sel == OP_MULH);
  assign bus.in_ready = (state_q == S_IDLE) && slot_free;
  assign load_single  = accept && !is_mul_op;
  assign load_mul     = (state_q == S_MUL) && (cnt_q == '0) && slot_free;
  assign mul_res      = mulh_q ? prod_q[2*WIDTH-1:WIDTH] : prod_q[WIDTH-1:0];
  assign mul_carry    = !mulh_q && (prod_q[2*WIDTH-1:WIDTH] != '0);

  // Multiplier sits in the low half and shifts out as the partial sum shifts in from the top.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mulh_d   = mulh_q;
    addend   = prod_q[0] ? mcand_q : {WIDTH{1'b0}};
    step_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    if (state_q == S_IDLE) begin
      if (accept && is_mul_op) begin
        state_d = S_MUL;
        cnt_d   = CNT_INIT;
        prod_d  = {{WIDTH{1'b0}}, bus.B};
        mcand_d = bus.A;
        mulh_d  = (bus.ALU_Sel == OP_MULH);
      end
    end else if (cnt_q != '0) begin
      prod_d = {step_sum, prod_q[WIDTH-1:1]};
      cnt_d  = cnt_q - CNT_ONE;
    end else if (slot_free) begin
      state_d = S_IDLE;
    end
  end
`else
  assign bus.in_ready = slot_free;
  assign load_single  = accept;
  assign load_mul     = 1'b0;
  assign mul_res      = '0;
  assign mul_carry    = 1'b0;
`endif

  always_comb begin
    alu_out_d   = alu_out_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    if (load_single) begin
      alu_out_d   = op_res;
      carry_d     = op_carry;
      ovf_d       = op_ovf;
      out_valid_d = 1'b1;
    end else if (load_mul) begin
      alu_out_d   = mul_res;
      carry_d     = mul_carry;
      ovf_d       = 1'b0;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef ALU_MUL_EN
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      prod_q      <= '0;
      mcand_q     <= '0;
      mulh_q      <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
`ifdef ALU_MUL_EN
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prod_q      <= prod_d;
      mcand_q     <= mcand_d;
      mulh_q      <= mulh_d;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.ALU_Out   = alu_out_q;
  assign bus.carry     = carry_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = (alu_out_q == '0);
  assign bus.neg       = alu_out_q[WIDTH-1];
endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard bench for alu_pipe (WIDTH=8), directed vectors for both ALU_MUL_EN builds
module tb_alu_pipe;
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, MUL = 4'd2, MULH = 4'd3, SHL = 4'd4, SHR = 4'd5,
                         ROL = 4'd6, ROR = 4'd7, AND = 4'd8, OR = 4'd9, XOR = 4'd10, NOR = 4'd11,
                         NAND = 4'd12, XNOR = 4'd13, GT = 4'd14, EQ = 4'd15;

  typedef struct {
    int         id;
    logic [7:0] res;
    logic       c;
    logic       o;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   next_id = 0;

  alu_pipe_if #(.WIDTH(8)) bus ();
  alu_pipe #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h expected no result", bus.ALU_Out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk($sformatf("res#%0d", e.id), bus.ALU_Out, e.res);
        chk($sformatf("carry#%0d", e.id), bus.carry, e.c);
        chk($sformatf("ovf#%0d", e.id), bus.ovf, e.o);
        chk($sformatf("zero#%0d", e.id), bus.zero, e.res == 8'h00);
        chk($sformatf("neg#%0d", e.id), bus.neg, e.res[7]);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                      input logic [7:0] er, input logic ec, input logic eo, input bit push);
    int n;
    n = 0;
    bus.A = a;
    bus.B = b;
    bus.ALU_Sel = op;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: op %0d never accepted", op);
    end else if (push) begin
      exp_q.push_back('{next_id, er, ec, eo});
      next_id++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int n;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.A = '0;
    bus.B = '0;
    bus.ALU_Sel = '0;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_alu_out", bus.ALU_Out, 0);
    chk("rst_zero", bus.zero, 1);
    chk("rst_carry", bus.carry, 0);
    chk("rst_ovf", bus.ovf, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    send(8'hB1, 8'h20, ADD, 8'hD1, 0, 0, 1);
    send(8'hB1, 8'h20, SUB, 8'h91, 0, 0, 1);
    send(8'h7F, 8'h01, ADD, 8'h80, 0, 1, 1);
    send(8'h00, 8'h01, SUB, 8'hFF, 1, 0, 1);
    send(8'hB1, 8'h03, SHL, 8'h88, 1, 0, 1);
    send(8'hB1, 8'h00, SHR, 8'hB1, 0, 0, 1);
    send(8'hB1, 8'h00, ROR, 8'hD8, 1, 0, 1);
    send(8'hB1, 8'h00, ROL, 8'h63, 1, 0, 1);
    send(8'h5A, 8'h5A, EQ,  8'h01, 0, 0, 1);
    send(8'h5A, 8'h5B, GT,  8'h00, 0, 0, 1);
    send(8'h5B, 8'h5A, GT,  8'h01, 0, 0, 1);
    send(8'h03, 8'h0F, SHL, 8'h80, 1, 0, 1);
    send(8'hC0, 8'h07, SHR, 8'h01, 1, 0, 1);
    send(8'hF0, 8'h3C, AND, 8'h30, 0, 0, 1);
    send(8'hF0, 8'h0F, OR,  8'hFF, 0, 0, 1);
    send(8'hFF, 8'h0F, XOR, 8'hF0, 0, 0, 1);
    send(8'h00, 8'h00, NOR, 8'hFF, 0, 0, 1);
    send(8'hFF, 8'hFF, NAND, 8'h00, 0, 0, 1);
    send(8'hAA, 8'h55, XNOR, 8'h00, 0, 0, 1);
    send(8'hFF, 8'h01, ADD, 8'h00, 1, 0, 1);

`ifdef ALU_MUL_EN
    send(8'hB1, 8'h20, MUL, 8'h20, 1, 0, 1);
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("mul_busy_cycles", n, 9);
    @(posedge clk);
    #1;
    send(8'hB1, 8'h20, MULH, 8'h16, 0, 0, 1);
    send(8'hFF, 8'hFF, MUL,  8'h01, 1, 0, 1);
    send(8'hFF, 8'hFF, MULH, 8'hFE, 0, 0, 1);
    send(8'h03, 8'h05, MUL,  8'h0F, 0, 0, 1);
`else
    send(8'hB1, 8'h20, MUL, 8'h00, 0, 1, 1);
    @(negedge clk);
    chk("mul_no_stall", bus.in_ready, 1);
    @(posedge clk);
    #1;
    send(8'hB1, 8'h20, MULH, 8'h00, 0, 1, 1);
`endif

    repeat (2) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(8'h10, 8'h20, ADD, 8'h30, 0, 0, 1);
    bus.A = 8'h0F;
    bus.B = 8'hFF;
    bus.ALU_Sel = XOR;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_out%0d", i), bus.ALU_Out, 8'h30);
      chk($sformatf("bp_hold_flags%0d", i), {bus.carry, bus.ovf, bus.zero, bus.neg}, 4'b0000);
      chk($sformatf("bp_hold_valid%0d", i), bus.out_valid, 1);
      chk($sformatf("bp_in_ready%0d", i), bus.in_ready, 0);
    end
    @(posedge clk);
    #1;
    exp_q.push_back('{next_id, 8'hF0, 1'b0, 1'b0});
    next_id++;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_same_cycle_accept", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

`ifdef ALU_MUL_EN
    send(8'hB1, 8'h20, MUL, 8'h00, 0, 0, 0);
    repeat (4) @(posedge clk);
`else
    bus.out_ready = 1'b0;
    send(8'h55, 8'h11, ADD, 8'h00, 0, 0, 0);
    @(posedge clk);
`endif
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_zero", bus.zero, 1);
    chk("mid_rst_alu_out", bus.ALU_Out, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", bus.in_ready, 1);
    chk("post_rst_out_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;
    send(8'h01, 8'h01, ADD, 8'h02, 0, 0, 1);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, handshaked successor to the 8-bit clocked ALU. Takes operand pairs through a valid/ready input channel and produces a registered result plus status flags on a valid/ready output channel. Adds a multi-cycle iterative shift-add multiplier (FSM), output backpressure and flags. Sits between the operand fetch/sequencer and the writeback/result consumer.

Parameters:
WIDTH, 8, operand and result width in bits (>=4, power of two); shift amount SW = $clog2(WIDTH).

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset; one clock; asynchronous, active-low
in_valid  in  1  operand request valid
in_ready  out  1  block can accept a request this cycle
A  in  WIDTH  operand A
B  in  WIDTH  operand B (shift ops use B[SW-1:0])
ALU_Sel  in  4  opcode
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
ALU_Out  out  WIDTH  result
carry  out  1  carry/borrow/shift-out/multiply-high-nonzero
zero  out  1  ALU_Out == 0
neg  out  1  ALU_Out[WIDTH-1]
ovf  out  1  signed overflow (ADD/SUB only)

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 MUL (low half), 3 MULH (high half, unsigned), 4 SHL, 5 SHR logical, 6 ROL by 1, 7 ROR by 1, 8 AND, 9 OR, 10 XOR, 11 NOR, 12 NAND, 13 XNOR, 14 GT (1 if A>B unsigned), 15 EQ (1 if A==B).
- Accept = in_valid && in_ready; A, B, ALU_Sel sampled only on accept.
- FSM states: IDLE, MUL. in_ready = (state==IDLE) && (!out_valid || out_ready).
- Single-cycle ops: result and flags registered on accept edge; out_valid high the next cycle (latency 1). Back-to-back accepts at full rate when out_ready=1.
- MUL/MULH: accept -> MUL state; counter loaded with WIDTH; one shift-add step per cycle into a 2*WIDTH product register. When the counter reaches 0 and the output slot is free (!out_valid || out_ready), load output, return to IDLE. Latency WIDTH+1 cycles with no backpressure. in_ready low throughout MUL.
- Output hold: while out_valid && !out_ready, ALU_Out and all flags stay stable. out_valid clears after a handshake when no new result loads in the same cycle.
- Flags: ADD carry=carry-out, ovf=signed overflow. SUB carry=borrow (A<B unsigned), ovf=signed overflow. SHL/SHR carry=last bit shifted out, 0 when the shift amount is 0. ROL/ROR carry=bit rotated around. MUL carry=1 if high half !=0. MULH carry=0. All other ops carry=0. ovf=0 except ADD/SUB. zero/neg are always derived from ALU_Out.
- Reset (rst_n low, any time including mid-multiply): state=IDLE, counter=0, product=0, out_valid=0, ALU_Out=0, carry=zero... all flags 0 except zero=1. Any in-flight multiply is discarded. in_ready=1 after reset release.
- The sequencer must not request while in_ready=0. in_valid during MUL is ignored, not queued.

Optional Feature:
ALU_MUL_EN. Defined: MUL/MULH use the iterative multiplier as above. Undefined: the MUL state and product datapath are not built. Opcodes 2/3 complete in 1 cycle with ALU_Out=0, carry=0, ovf=1 (illegal-op marker), zero=1. in_ready never drops for opcode reasons.

Test Plan:
WIDTH=8, out_ready=1, A=0xB1, B=0x20, ADD -> next cycle ALU_Out=0xD1, carry=0, ovf=0, neg=1, zero=0. SUB -> 0x91, carry=0.
A=0x7F, B=0x01, ADD -> 0x80, ovf=1, neg=1. A=0x00, B=0x01, SUB -> 0xFF, carry=1.
ALU_MUL_EN defined: A=0xB1, B=0x20, MUL -> in_ready low 9 cycles, then ALU_Out=0x20, carry=1. MULH -> 0x16, carry=0.
A=0xB1, B=3, SHL -> 0x88, carry=1. SHR B=0 -> 0xB1, carry=0. ROR -> 0xD8, carry=1. EQ A=B=0x5A -> 0x01.
Backpressure: out_ready=0 with a result held for 4 cycles -> ALU_Out/flags stable, in_ready=0. Raise out_ready -> handshake, next op accepted the same cycle.
Pull rst_n low at multiply step 4 -> out_valid=0, zero=1, in_ready=1 after release. Then ADD 0x01+0x01 -> 0x02. Without ALU_MUL_EN: MUL -> 1-cycle result 0x00, ovf=1.
